// File: rtl/clk_rst_pkg.sv
// Shared types and default timing constants for the clock/reset sequencer.
package clk_rst_pkg;

    typedef enum logic [2:0] {
        WAIT_LOCK = 3'd0,
        STABLE    = 3'd1,
        BRAM_REL  = 3'd2,
        SYS_REL   = 3'd3,
        RUN       = 3'd4
    } state_t;

    localparam int DEF_STABLE_CYCLES = 1024;
    localparam int DEF_BRAM_HOLD     = 16;

endpackage

// File: rtl/clk_rst_seq_sync_bit.sv
// Multi-stage single-bit synchroniser with async active-low clear.
module sync_bit #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] ff;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) ff <= '0;
        else        ff <= {ff[STAGES-2:0], d};
    end

    assign q = ff[STAGES-1];

endmodule

// File: rtl/clk_rst_seq.sv
// Reset sequencer: debounces MMCM lock, releases BRAM reset then system reset,
// and re-sequences on lock loss or software request.
module clk_rst_seq
    import clk_rst_pkg::*;
#(
    parameter int SYNC_STAGES   = 2,
    parameter int STABLE_CYCLES = DEF_STABLE_CYCLES,
    parameter int BRAM_HOLD     = DEF_BRAM_HOLD,
    parameter int LOSS_CNT_W    = 8
) (
    input  logic                  clk0,
    input  logic                  rst_n,
    input  logic                  locked,
    input  logic                  soft_rst_req,
    output logic                  bram_rst_n,
    output logic                  sys_rst_n,
    output logic                  ready,
    output logic                  lock_lost,
    output logic [LOSS_CNT_W-1:0] loss_count,
    output logic [2:0]            state_o
);

    localparam int CNT_MAX = (STABLE_CYCLES > BRAM_HOLD) ? STABLE_CYCLES : BRAM_HOLD;
    // BRAM_REL counts 0..BRAM_HOLD inclusive, so the counter must hold CNT_MAX itself.
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    logic             locked_s;
    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic             abort;
    logic             after_sys;

    sync_bit #(.STAGES(SYNC_STAGES)) u_lock_sync (
        .clk   (clk0),
        .rst_n (rst_n),
        .d     (locked),
        .q     (locked_s)
    );

    assign abort     = (state != WAIT_LOCK) && (!locked_s || soft_rst_req);
    assign after_sys = (state == SYS_REL) || (state == RUN);

    always_ff @(posedge clk0 or negedge rst_n) begin
        if (!rst_n) begin
            state      <= WAIT_LOCK;
            cnt        <= '0;
            bram_rst_n <= 1'b0;
            sys_rst_n  <= 1'b0;
            ready      <= 1'b0;
            lock_lost  <= 1'b0;
            loss_count <= '0;
        end else if (abort) begin
            state      <= WAIT_LOCK;
            cnt        <= '0;
            bram_rst_n <= 1'b0;
            sys_rst_n  <= 1'b0;
            ready      <= 1'b0;
            // A lock drop wins over a coincident soft request and is counted.
            if (!locked_s && after_sys) begin
                lock_lost <= 1'b1;
                if (loss_count != {LOSS_CNT_W{1'b1}})
                    loss_count <= loss_count + LOSS_CNT_W'(1);
            end
        end else begin
            case (state)
                WAIT_LOCK: begin
                    cnt <= '0;
                    if (locked_s) state <= STABLE;
                end
                STABLE: begin
                    if (cnt == CNT_W'(STABLE_CYCLES - 1)) begin
                        state      <= BRAM_REL;
                        cnt        <= '0;
                        bram_rst_n <= 1'b1;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                BRAM_REL: begin
                    if (cnt == CNT_W'(BRAM_HOLD)) begin
                        state     <= SYS_REL;
                        cnt       <= '0;
                        sys_rst_n <= 1'b1;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                SYS_REL: begin
                    state <= RUN;
                    ready <= 1'b1;
                end
                RUN: ;
                default: begin
                    state      <= WAIT_LOCK;
                    cnt        <= '0;
                    bram_rst_n <= 1'b0;
                    sys_rst_n  <= 1'b0;
                    ready      <= 1'b0;
                end
            endcase
        end
    end

    assign state_o = state;

endmodule
